// File: rtl/sram_bus_arbiter_pkg.sv
// sram_bus_arbiter_pkg: owner tags, size encodings and request bundle shared by the arbiter
package sram_bus_arbiter_pkg;
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam int REQ_W = 71;
  typedef logic [REQ_W-1:0] sram_req_t;
endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: in-order 1-bit owner tag FIFO tracking outstanding requests
module arb_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     tag,
  input  logic                     pop,
  output logic                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] tags;
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) tags[wp] <= tag;
  always_ff @(posedge clk)
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  assign head  = tags[rp];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like port between inst and data requesters with in-order response routing
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_stray_data_ok
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic lock_valid, lock_owner, owner, owner_req, inst_gnt, acc, pop, head, full, empty;
  logic [SW-1:0] starve_cnt;
  logic [$clog2(MAX_OUTSTANDING):0] count;
  sram_req_t inst_bus, data_bus, mem_bus;
  assign inst_bus = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign data_bus = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
  always_comb begin
    owner     = lock_valid ? lock_owner :
                (starve_cnt == SW'(STARVE_LIMIT) && inst_req) ? OWNER_INST :
                data_req ? OWNER_DATA : OWNER_INST;
    owner_req = owner == OWNER_DATA ? data_req : inst_req;
    mem_req   = !full && owner_req;
    mem_bus   = owner == OWNER_DATA ? data_bus : inst_bus;
    inst_gnt  = mem_req && owner == OWNER_INST;
  end
  assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = mem_bus;
  assign acc          = mem_req & mem_addr_ok;
  assign inst_addr_ok = acc & (owner == OWNER_INST);
  assign data_addr_ok = acc & (owner == OWNER_DATA);
  assign pop          = mem_data_ok & (|count);
  assign inst_data_ok = pop & (head == OWNER_INST);
  assign data_data_ok = pop & (head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  always_ff @(posedge clk)
    if (reset) begin
      lock_valid        <= 1'b0;
      lock_owner        <= OWNER_INST;
      starve_cnt        <= '0;
      err_stray_data_ok <= 1'b0;
    end else begin
      // a dropped req leaves mem_req low, which also releases the lock
      lock_valid        <= mem_req & ~mem_addr_ok;
      lock_owner        <= owner;
      starve_cnt        <= (!inst_req || inst_addr_ok) ? '0 :
                           (!inst_gnt && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
      err_stray_data_ok <= err_stray_data_ok | (mem_data_ok & empty);
    end
  arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (acc),
    .tag   (owner),
    .pop   (pop),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed scoreboard bench for sram_bus_arbiter
module tb_sram_bus_arbiter;
  import sram_bus_arbiter_pkg::*;
  logic clk = 1'b0, reset;
  logic inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0] inst_size;
  logic [3:0] inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0] data_size;
  logic [3:0] data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok, err_stray_data_ok;
  logic [1:0] mem_size;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int n_tests = 0, n_fail = 0;
  logic exp_q[$];
  always #5 clk = ~clk;
  sram_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err_stray_data_ok(err_stray_data_ok)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic ir, dr, mok, dok, input logic [31:0] rd,
                      input logic ei, ed, input string tag);
    logic o;
    @(negedge clk);
    inst_req = ir; data_req = dr; mem_addr_ok = mok; mem_data_ok = dok; mem_rdata = rd;
    #1;
    check({tag, "_iaok"}, {31'b0, inst_addr_ok}, {31'b0, ei});
    check({tag, "_daok"}, {31'b0, data_addr_ok}, {31'b0, ed});
    if (dok && exp_q.size() > 0) begin
      o = exp_q.pop_front();
      check({tag, "_idok"}, {31'b0, inst_data_ok}, {31'b0, o == OWNER_INST});
      check({tag, "_ddok"}, {31'b0, data_data_ok}, {31'b0, o == OWNER_DATA});
      check({tag, "_rdata"}, o == OWNER_INST ? inst_rdata : data_rdata, rd);
    end else begin
      check({tag, "_idok0"}, {31'b0, inst_data_ok}, 32'd0);
      check({tag, "_ddok0"}, {31'b0, data_data_ok}, 32'd0);
    end
    if (ei) exp_q.push_back(OWNER_INST);
    if (ed) exp_q.push_back(OWNER_DATA);
  endtask
  initial begin
    reset = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = SIZE_W; inst_wstrb = 4'hF;
    inst_addr = 32'h1C00_0000; inst_wdata = 32'h0;
    data_req = 0; data_wr = 0; data_size = SIZE_W; data_wstrb = 4'hF;
    data_addr = 32'h0000_1000; data_wdata = 32'h1234_5678;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_iaok", {31'b0, inst_addr_ok}, 32'd0);
    check("rst_daok", {31'b0, data_addr_ok}, 32'd0);
    check("rst_err", {31'b0, err_stray_data_ok}, 32'd0);
    step(1, 1, 1, 0, 0, 0, 1, "t1_c0");
    check("t1_addr0", mem_addr, 32'h0000_1000);
    step(1, 0, 1, 0, 0, 1, 0, "t1_c1");
    check("t1_addr1", mem_addr, 32'h1C00_0000);
    step(0, 0, 0, 1, 32'h11, 0, 0, "t1_r0");
    step(0, 0, 0, 1, 32'h22, 0, 0, "t1_r1");
    step(0, 1, 0, 0, 0, 0, 0, "t2_c1");
    check("t2_req1", {31'b0, mem_req}, 32'd1);
    check("t2_addr1", mem_addr, 32'h0000_1000);
    step(1, 1, 0, 0, 0, 0, 0, "t2_c2");
    check("t2_addr2", mem_addr, 32'h0000_1000);
    step(1, 1, 1, 0, 0, 0, 1, "t2_c3");
    check("t2_addr3", mem_addr, 32'h0000_1000);
    step(1, 0, 1, 0, 0, 1, 0, "t2_c4");
    step(0, 0, 0, 1, 32'h33, 0, 0, "t2_r0");
    step(0, 0, 0, 1, 32'h44, 0, 0, "t2_r1");
    for (int k = 1; k <= 10; k++)
      step(1, 1, 1, k > 1, 32'hB000_0000 + k, k == 9, k != 9, $sformatf("t3_c%0d", k));
    step(0, 0, 0, 1, 32'hB000_000B, 0, 0, "t3_drain");
    for (int k = 0; k < 4; k++) step(1, 0, 1, 0, 0, 1, 0, "t4_fill");
    step(1, 0, 1, 0, 0, 0, 0, "t4_full");
    check("t4_full_req", {31'b0, mem_req}, 32'd0);
    step(1, 0, 1, 1, 32'hC0, 0, 0, "t4_pop");
    check("t4_pop_req", {31'b0, mem_req}, 32'd0);
    step(1, 0, 1, 0, 0, 1, 0, "t4_refill");
    step(1, 0, 1, 0, 0, 0, 0, "t4_full2");
    check("t4_full2_req", {31'b0, mem_req}, 32'd0);
    for (int k = 1; k <= 4; k++) step(0, 0, 0, 1, 32'hC0 + k, 0, 0, "t4_drain");
    step(1, 0, 1, 0, 0, 1, 0, "t5_i0");
    step(0, 1, 1, 0, 0, 0, 1, "t5_d1");
    step(0, 1, 1, 0, 0, 0, 1, "t5_d2");
    step(1, 0, 1, 0, 0, 1, 0, "t5_i3");
    for (int k = 1; k <= 4; k++) step(0, 0, 0, 1, 32'hAAAA_0000 + k, 0, 0, $sformatf("t5_r%0d", k));
    check("t6_err_pre", {31'b0, err_stray_data_ok}, 32'd0);
    step(0, 0, 0, 1, 32'h5555, 0, 0, "t6_stray");
    step(0, 0, 0, 0, 0, 0, 0, "t6_idle0");
    check("t6_err1", {31'b0, err_stray_data_ok}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, "t6_idle1");
    check("t6_err2", {31'b0, err_stray_data_ok}, 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, "t7_lock");
    check("t7_lock_addr", mem_addr, 32'h1C00_0000);
    @(negedge clk);
    reset = 1'b1; inst_req = 1; data_req = 1; mem_addr_ok = 0; mem_data_ok = 0;
    @(negedge clk) reset = 1'b0;
    #1;
    check("t7_err_clr", {31'b0, err_stray_data_ok}, 32'd0);
    check("t7_req", {31'b0, mem_req}, 32'd1);
    check("t7_addr", mem_addr, 32'h0000_1000);
    step(1, 1, 1, 0, 0, 0, 1, "t7_acc");
    step(0, 0, 0, 1, 32'h77, 0, 0, "t7_resp");
    check("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
Shares one SRAM-like memory port between the IF-stage instruction requester and the EX/MEM-stage data requester. A request is issued when its addr_ok handshake completes, and its response is collected in MEM when data_ok arrives.
- Grants one request per cycle; data requests win by default, with an anti-starvation override for fetch.
- Holds each grant stable until addr_ok.
- Records the owner of every accepted request in an in-order tag FIFO, so each downstream data_ok is returned to the correct requester.

Parameters:
MAX_OUTSTANDING, 4, depth of the owner-tag FIFO (power of 2, ≥2); also the maximum number of accepted requests whose data_ok has not yet returned.
STARVE_LIMIT, 8, number of consecutive cycles a pending inst request may lose to data before inst gets forced priority.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
inst_req  in  1  fetch request valid
inst_wr  in  1  write flag (normally 0)
inst_size  in  2  0=byte, 1=half, 2=word
inst_wstrb  in  4  byte enables
inst_addr  in  32  address
inst_wdata  in  32  write data
inst_addr_ok  out  1  fetch request accepted
inst_data_ok  out  1  fetch response valid
inst_rdata  out  32  fetch read data
data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  same fields for the data requester
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response valid (feeds MEM data_sram_data_ok)
data_rdata  out  32  data read data
mem_req  out  1  downstream request valid
mem_wr  out  1  downstream write flag
mem_size  out  2  downstream size
mem_wstrb  out  4  downstream byte enables
mem_addr  out  32  downstream address
mem_wdata  out  32  downstream write data
mem_addr_ok  in  1  downstream accept
mem_data_ok  in  1  downstream response valid
mem_rdata  in  32  downstream read data
err_stray_data_ok  out  1  sticky flag: mem_data_ok seen while the tag FIFO was empty

Behaviour:
- Reset (synchronous, active-high): clear FIFO count, pointers, lock, starve counter and err_stray_data_ok.
  - After reset, all *_addr_ok, *_data_ok and mem_req outputs are 0 until a request arrives.
- Grant (combinational):
  - If count == MAX_OUTSTANDING, no grant: mem_req = 0.
  - Else if lock_valid, grant lock_owner.
  - Else if starve_cnt == STARVE_LIMIT and inst_req, grant inst.
  - Else grant data if data_req, else inst if inst_req.
- Mux: mem_* = granted requester's fields; mem_req = granted requester's req.
- Accept: granted requester's addr_ok = mem_req & mem_addr_ok. The other requester's addr_ok = 0. Zero added latency.
- Lock:
  - mem_req & !mem_addr_ok: set lock_valid, lock_owner = granted owner.
  - mem_addr_ok: clear lock.
  - Requesters must hold req/fields stable until addr_ok; the lock guarantees the grant does not switch meanwhile.
  - If a locked requester drops req (protocol violation), clear the lock next cycle.
- Starve counter:
  - Increment, saturating at STARVE_LIMIT, each cycle inst_req is high and inst is not granted.
  - Reset to 0 on inst accept or when inst_req is low.
- Tag FIFO:
  - Push owner tag on mem_req & mem_addr_ok.
  - Pop on mem_data_ok when count > 0.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Response:
  - inst_data_ok = mem_data_ok & count > 0 & head == INST; data_data_ok is the same with head == DATA.
  - inst_rdata = data_rdata = mem_rdata (broadcast); only the addressed requester's data_ok qualifies it.
- Stray response: mem_data_ok with count == 0 causes no pop, no data_ok, and sets err_stray_data_ok until reset.
- Ordering: responses are assumed in order (single downstream port, in-order memory). Writes also receive data_ok, and they are counted and routed like reads.
- Pipeline flush (exception) is not handled here. Requesters must still absorb data_ok for already-accepted requests; the arbiter never drops a tag.

Decomposition:
- Shared package:
  - OWNER_INST = 1'b0, OWNER_DATA = 1'b1
  - size encodings SIZE_B/H/W
  - packed SRAM-like request bundle width, 71 bits = {wr, size, wstrb, addr, wdata}
- One sub-module: arb_tag_fifo, a 1-bit-wide FIFO of depth MAX_OUTSTANDING with push, pop, head, count, full and empty.

Test Plan:
- Simultaneous inst_req and data_req at addresses 0x1C000000/0x00001000, mem_addr_ok = 1 -> data accepted cycle 0, inst accepted cycle 1. A later 2-cycle data_ok pair returns data then inst data_ok.
- data_req first with mem_addr_ok held low 3 cycles while inst_req rises -> mem_addr stays 0x1000 all 3 cycles; data_addr_ok on cycle 3 only.
- data_req held continuously, inst_req high -> inst granted in exactly cycle STARVE_LIMIT+1 = 9; starve counter then returns to 0.
- 4 inst requests accepted, no data_ok -> mem_req = 0 on the 5th. One mem_data_ok in the same cycle as a new request accepts it next cycle; count stays 4.
- Interleaved accepts I, D, D, I; mem_data_ok with rdata 0xAAAA0001..4 -> inst, data, data, inst data_ok in that order with matching rdata.
- mem_data_ok with FIFO empty -> no data_ok pulses, err_stray_data_ok = 1 until reset. Reset asserted mid-lock -> lock cleared, mem_req follows fresh arbitration next cycle.
